fmul_arbiter: RTL
=================

# fmul_arbiter

Round-robin scheduler that shares one pipelined `fmul` instance among N requesters. It accepts at most one multiply per cycle and drives the multiplier's operand inputs from registers. It tracks each in-flight operation with a requester-tag pipeline matched to the multiplier latency, then returns the registered product to the originating requester. It sits between the FPU-issuing units and the `fmul` datapath; the multiplier itself is unmodified.

## Interface
- `N`, 4: number of requesters (2..8).
- `MUL_LAT`, 3: multiplier latency in clock edges, from operand sampled to `result` updated.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hold`  in  1  when high, no new request is granted; in-flight ops still complete.
- `req_valid`  in  N  request pending, one bit per requester.
- `req_ready`  out  N  one-hot grant, combinational; accept when `req_valid[i] && req_ready[i]`.
- `req_op1`  in  32*N  operand 1; requester i occupies `[32i+31:32i]`.
- `req_op2`  in  32*N  operand 2, same packing.
- `rsp_valid`  out  N  one-hot, one-cycle pulse marking the response owner.
- `rsp_result`  out  32  product.
- `rsp_uf`  out  1  exponent underflow flag, qualified by `rsp_valid`.
- `mul_op1`  out  32  to `fmul.op1`, registered.
- `mul_op2`  out  32  to `fmul.op2`, registered.
- `mul_result`  in  32  from `fmul.result`.
- `mul_ready`  in  1  from `fmul.ready`; 1 means the exponent is in range and `result` was updated.
- `mul_valid`  in  1  from `fmul.valid`; ignored.
- `idle`  out  1  high when no op is in flight and no response is pending.

## Operation
- **Arbitration**
  - Pointer `ptr` (0..N-1) holds the highest-priority index.
  - Grant goes to the first i with `req_valid[i]`, scanning `ptr, ptr+1, …, N-1, 0, …` (wrap-around).
  - `req_ready` is all-zero when `hold`, `rst`, or no `req_valid` bit is set.
  - On accept of requester g: `ptr <= (g+1) mod N`. With no accept, `ptr` is unchanged.
- **Issue**
  - On accept: `mul_op1/mul_op2 <=` operands of g.
  - Tag stage 0 `<= {1, g}`. Without an accept, tag stage 0 `<= {0, x}` and `mul_op*` hold their values (the multiplier computes garbage that the arbiter discards).
- **Tag pipeline**
  - MUL_LAT+1 stages (0..MUL_LAT); each shifts one stage per cycle, never stalls.
  - Stage MUL_LAT aligns with the cycle in which `mul_result` holds the product of that op.
- **Response**
  - When stage MUL_LAT is valid with tag t: `rsp_valid <= onehot(t)`.
  - Result capture:
    - `mul_ready=1`: `rsp_result <= mul_result`, `rsp_uf <= 0`.
    - `mul_ready=0`: `rsp_result <= 32'h0`, `rsp_uf <= 1`.
  - Otherwise `rsp_valid <= 0`; `rsp_result` and `rsp_uf` hold their values.
- **No response backpressure.** Requesters must sink `rsp_valid` every cycle. Responses return in issue order.
- **`idle`** = no valid tag stage AND `rsp_valid == 0`. It is combinational from registers.
- **Reset**
  - Register values: `ptr=0`, all tag stages invalid, `mul_op1=mul_op2=0`, `rsp_valid=0`, `rsp_result=0`, `rsp_uf=0`.
  - Resulting outputs: `req_ready=0` while `rst` is high, `idle=1` after the reset edge.
  - Reset mid-operation drops every in-flight op: no `rsp_valid` is ever produced for it. Stale `fmul` contents are ignored because their tags are invalid.

## Timing
- Accept in cycle c: `mul_op*` is valid in c+1; `fmul` result is valid in c+1+MUL_LAT; `rsp_valid` and `rsp_result` are valid in c+2+MUL_LAT (c+5 by default).
- Throughput is one op per cycle sustained, any mix of requesters.
- A single requester with the others idle is granted every cycle, and `ptr` re-wraps to it.
- `hold` rising in cycle c: no accept in c. Ops accepted before c still respond on schedule.
- `rst` and `req_valid` together: reset wins, no accept.

## Test plan
- **Single request:**
  - Stimulus: requester 2 presents op1=0x40000000 (2.0), op2=0x40400000 (3.0) in cycle 0.
  - Response: `req_ready=4'b0100` in cycle 0; `rsp_valid=4'b0100`, `rsp_result=0x40C00000`, `rsp_uf=0` in cycle 5; `idle=1` from cycle 6.
- **Contention:**
  - Stimulus: all four requesters valid from cycle 0 and held valid; each deasserts after its accept.
  - Response: grants go to 0,1,2,3 in cycles 0..3; responses arrive on 0,1,2,3 in cycles 5..8.
- **Round-robin fairness:**
  - Stimulus: requesters 0 and 1 continuously valid.
  - Response: grants alternate 0,1,0,1; neither requester waits more than one cycle.
- **Underflow:**
  - Stimulus: op1=op2=0x00800000.
  - Response: `rsp_uf=1`, `rsp_result=0x00000000`.
  - Follow-up: the next op 0x3FC00000×0x3FC00000 returns 0x40100000 with `rsp_uf=0`.
- **Hold:**
  - Stimulus: `hold=1` while requester 1 is valid for 10 cycles.
  - Response: `req_ready=0` throughout; the accept occurs in the first cycle after `hold` falls.
- **Reset mid-flight:**
  - Stimulus: accept ops in cycles 0 and 1; assert `rst` in cycle 2.
  - Response: no `rsp_valid` in cycles 3..10; `idle=1` after reset; `ptr` returns to 0, so requester 0 wins a subsequent 3-way contention.

Source files
------------

// File: rtl/fmul_arbiter.sv
// rtl/fmul_arbiter.sv - round-robin scheduler sharing one pipelined fmul among N requesters
module fmul_arbiter #(
    parameter int N       = 4,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [32*N-1:0] req_op1,
    input  logic [32*N-1:0] req_op2,
    output logic [N-1:0]    rsp_valid,
    output logic [31:0]     rsp_result,
    output logic            rsp_uf,
    output logic [31:0]     mul_op1,
    output logic [31:0]     mul_op2,
    input  logic [31:0]     mul_result,
    input  logic            mul_ready,
    input  logic            mul_valid,
    output logic            idle
);

    localparam int TW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // fmul.valid carries no information the tag pipeline does not already have
    logic unused_mul_valid;
    assign unused_mul_valid = mul_valid;

    logic [TW-1:0] ptr;
    logic [TW-1:0] grant_idx;
    logic          grant_found;
    logic          accept;
    logic [31:0]   sel_op1;
    logic [31:0]   sel_op2;

    // Requester tag travelling alongside each op; stage MUL_LAT lines up with mul_result
    logic          tag_vld [0:MUL_LAT];
    logic [TW-1:0] tag_id  [0:MUL_LAT];
    logic          any_tag_vld;

    // Wrap-around priority scan starting at ptr; also picks the winner's operands
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_op1     = '0;
        sel_op2     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = TW'(idx);
                sel_op1     = req_op1[idx*32 +: 32];
                sel_op2     = req_op2[idx*32 +: 32];
            end
        end
    end

    // Grant is suppressed by hold and by reset, which always wins over a request
    always_comb begin
        accept    = grant_found && !hold && !rst;
        req_ready = accept ? (ONE << grant_idx) : '0;
    end

    // Nothing in flight and no response on the outputs
    always_comb begin
        any_tag_vld = 1'b0;
        for (int s = 0; s <= MUL_LAT; s++) begin
            any_tag_vld = any_tag_vld | tag_vld[s];
        end
        idle = !any_tag_vld && (rsp_valid == '0);
    end

    // Pointer advance and operand registers; operands hold when nothing is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            mul_op1 <= '0;
            mul_op2 <= '0;
        end else if (accept) begin
            ptr     <= (grant_idx == TW'(N-1)) ? '0 : grant_idx + 1'b1;
            mul_op1 <= sel_op1;
            mul_op2 <= sel_op2;
        end
    end

    // Tag shift register: never stalls, an empty slot enters whenever there is no accept
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_vld[s] <= 1'b0;
                tag_id[s]  <= '0;
            end
        end else begin
            tag_vld[0] <= accept;
            tag_id[0]  <= grant_idx;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Capture the product for the owning requester; out-of-range exponent returns zero plus flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_uf     <= 1'b0;
        end else if (tag_vld[MUL_LAT]) begin
            rsp_valid <= ONE << tag_id[MUL_LAT];
            if (mul_ready) begin
                rsp_result <= mul_result;
                rsp_uf     <= 1'b0;
            end else begin
                rsp_result <= 32'h0;
                rsp_uf     <= 1'b1;
            end
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule
